// File: rtl/ycr_sleep_pkg.sv
// ycr_sleep_pkg: shared types and constants for the sleep/wake controller
// Contents: sleep_state_e FSM encoding, counter width, minimum SLEEP hold,
// and a saturating increment helper for the 4-bit counters.
package ycr_sleep_pkg;
    localparam int SLEEP_CNT_W    = 4;
    localparam int SLEEP_MIN_HOLD = 3;
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SLEEP = 2'd2,
        WAKE  = 2'd3
    } sleep_state_e;
    function automatic logic [SLEEP_CNT_W-1:0] sat_inc(input logic [SLEEP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/ycr_sleep_ctrl_if.sv
// ycr_sleep_ctrl_if: core/gate/interrupt signal bundle of the sleep controller
// master: drives wfi_req, bus_busy, wakeup, irq_raw, irq_en, irq_clr
//         and observes dst_idle, sleep_ack, irq1..3, irq_pending
// slave : the controller side (ycr_sleep_ctrl)
interface ycr_sleep_ctrl_if;
    logic       wfi_req;
    logic       bus_busy;
    logic       wakeup;
    logic [2:0] irq_raw;
    logic [2:0] irq_en;
    logic [2:0] irq_clr;
    logic       dst_idle;
    logic       sleep_ack;
    logic       irq1;
    logic       irq2;
    logic       irq3;
    logic [2:0] irq_pending;
    modport master (
        output wfi_req, bus_busy, wakeup, irq_raw, irq_en, irq_clr,
        input  dst_idle, sleep_ack, irq1, irq2, irq3, irq_pending
    );
    modport slave (
        input  wfi_req, bus_busy, wakeup, irq_raw, irq_en, irq_clr,
        output dst_idle, sleep_ack, irq1, irq2, irq3, irq_pending
    );
endinterface

// File: rtl/ctech_dsync_high.sv
// ctech_dsync_high: two-flop synchroniser, resets low
// Ports: clk_in, reset_n (async, active-low), d (async input), q (synced output)
module ctech_dsync_high (
    input  logic clk_in,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic s1;
    always_ff @(posedge clk_in or negedge reset_n)
        if (!reset_n) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
endmodule

// File: rtl/ycr_irq_latch.sv
// ycr_irq_latch: one interrupt source, synchronised and latched into a sticky pending bit
// Ports: clk_in, reset_n (async, active-low), irq_raw (async source),
//        irq_clr (write-1 clear), pending (sticky status)
// Macro YCR_IRQ_EDGE_EN: set pending on the synced rising edge instead of the level.
module ycr_irq_latch (
    input  logic clk_in,
    input  logic reset_n,
    input  logic irq_raw,
    input  logic irq_clr,
    output logic pending
);
    logic s;
    logic set;
    ctech_dsync_high u_sync (.clk_in(clk_in), .reset_n(reset_n), .d(irq_raw), .q(s));
`ifdef YCR_IRQ_EDGE_EN
    logic s_d;
    always_ff @(posedge clk_in or negedge reset_n)
        if (!reset_n) s_d <= 1'b0;
        else          s_d <= s;
    assign set = s & ~s_d;
`else
    assign set = s;
`endif
    // set has priority over a same-cycle clear
    always_ff @(posedge clk_in or negedge reset_n)
        if (!reset_n) pending <= 1'b0;
        else          pending <= set | (pending & ~irq_clr);
endmodule

// File: rtl/ycr_sleep_ctrl.sv
// ycr_sleep_ctrl: WFI/bus-quiescence qualifier and interrupt wake front-end for the core clock gate
// Ports: clk_in (ungated clock), reset_n (async, active-low),
//        sif (ycr_sleep_ctrl_if.slave: wfi_req, bus_busy, wakeup, irq_raw/en/clr in;
//             dst_idle, sleep_ack, irq1..3, irq_pending out)
// Parameters: DRAIN_CYC (1..15) idle cycles before sleep, WAKE_HOLD (1..15) post-wake hold.
// Macro YCR_IRQ_EDGE_EN selects edge-detected interrupt pending (see ycr_irq_latch).
module ycr_sleep_ctrl
    import ycr_sleep_pkg::*;
#(
    parameter int DRAIN_CYC = 4,
    parameter int WAKE_HOLD = 4
) (
    input logic           clk_in,
    input logic           reset_n,
    ycr_sleep_ctrl_if.slave sif
);
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_SLEEP = SLEEP;
    localparam logic [1:0] ST_WAKE  = WAKE;
    localparam logic [SLEEP_CNT_W-1:0] DRAIN_LIM = SLEEP_CNT_W'(DRAIN_CYC);
    localparam logic [SLEEP_CNT_W-1:0] HOLD_LAST = SLEEP_CNT_W'(WAKE_HOLD - 1);
    localparam logic [1:0] GUARD_OK = 2'(SLEEP_MIN_HOLD - 1);
    logic [2:0]             pend;
    logic [2:0]             irq_q;
    logic                   wfi_r;
    logic                   wake_seen;
    logic                   idle_q;
    logic [1:0]             state;
    logic [1:0]             state_nx;
    logic [1:0]             guard;
    logic [SLEEP_CNT_W-1:0] drain_cnt;
    logic [SLEEP_CNT_W-1:0] hold_cnt;
    logic                   irq_act;
    logic                   wfi_rise;
    logic                   sleep_exit;
    for (genvar i = 0; i < 3; i++) begin : g_irq
        ycr_irq_latch u_irq (
            .clk_in (clk_in),
            .reset_n(reset_n),
            .irq_raw(sif.irq_raw[i]),
            .irq_clr(sif.irq_clr[i]),
            .pending(pend[i])
        );
    end
    assign irq_act  = |(pend & sif.irq_en);
    assign wfi_rise = sif.wfi_req & ~wfi_r;
    // a wakeup pulse seen before the minimum hold elapses is remembered in wake_seen
    assign sleep_exit = (guard >= GUARD_OK) & (sif.wakeup | wake_seen | ~sif.wfi_req);
    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN:   state_nx = (wfi_rise && !irq_act) ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_nx = (irq_act || !sif.wfi_req) ? ST_RUN :
                                 (drain_cnt == DRAIN_LIM) ? ST_SLEEP : ST_DRAIN;
            ST_SLEEP: state_nx = sleep_exit ? ST_WAKE : ST_SLEEP;
            default:  state_nx = (hold_cnt == HOLD_LAST) ? ST_RUN : ST_WAKE;
        endcase
    end
    always_ff @(posedge clk_in or negedge reset_n)
        if (!reset_n) begin
            state     <= ST_RUN;
            wfi_r     <= 1'b0;
            drain_cnt <= '0;
            hold_cnt  <= '0;
            guard     <= 2'd0;
            wake_seen <= 1'b0;
            idle_q    <= 1'b0;
            irq_q     <= 3'b000;
        end else begin
            state     <= state_nx;
            wfi_r     <= sif.wfi_req;
            drain_cnt <= (state != ST_DRAIN || sif.bus_busy) ? '0 : sat_inc(drain_cnt);
            hold_cnt  <= (state == ST_WAKE) ? sat_inc(hold_cnt) : '0;
            guard     <= (state == ST_SLEEP) ? guard + {1'b0, ~&guard} : 2'd0;
            wake_seen <= (state == ST_SLEEP) & (wake_seen | sif.wakeup);
            idle_q    <= state_nx == ST_SLEEP;
            irq_q     <= pend & sif.irq_en;
        end
    assign sif.dst_idle    = idle_q;
    assign sif.sleep_ack   = idle_q;
    assign sif.irq1        = irq_q[0];
    assign sif.irq2        = irq_q[1];
    assign sif.irq3        = irq_q[2];
    assign sif.irq_pending = pend;
endmodule

// File: tb/tb_ycr_sleep_ctrl.sv
// tb_ycr_sleep_ctrl: directed and randomized checks of ycr_sleep_ctrl against a behavioural model
module tb_ycr_sleep_ctrl;
    localparam int DC = 4;
    localparam int WH = 4;
`ifdef YCR_IRQ_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif
    localparam int M_RUN = 0, M_DRAIN = 1, M_SLEEP = 2, M_WAKE = 3;

    logic clk_in = 1'b0;
    logic reset_n = 1'b0;
    int   passed = 0;
    int   total = 0;

    ycr_sleep_ctrl_if sif ();
    ycr_sleep_ctrl #(.DRAIN_CYC(DC), .WAKE_HOLD(WH)) dut (
        .clk_in (clk_in),
        .reset_n(reset_n),
        .sif    (sif)
    );

    always #5 clk_in = ~clk_in;

    // model: mode plus time spent in it (unbounded), interrupt pipeline as plain vectors
    int         m_mode, m_t;
    bit         m_wseen, m_wfi_r, m_idle;
    logic [2:0] m_s1, m_s2, m_prev, m_pend, m_irq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_mode = M_RUN; m_t = 0; m_wseen = 0; m_wfi_r = 0; m_idle = 0;
        m_s1 = 0; m_s2 = 0; m_prev = 0; m_pend = 0; m_irq = 0;
    endtask

    task automatic check_outs();
        chk("dst_idle", 32'(sif.dst_idle), 32'(m_idle));
        chk("sleep_ack", 32'(sif.sleep_ack), 32'(m_idle));
        chk("irq_lines", 32'({sif.irq3, sif.irq2, sif.irq1}), 32'(m_irq));
        chk("irq_pending", 32'(sif.irq_pending), 32'(m_pend));
    endtask

    task automatic step();
        logic [2:0] set;
        bit act, rise;
        int nm, nt;
        set  = EDGE ? (m_s2 & ~m_prev) : m_s2;
        act  = |(m_pend & sif.irq_en);
        rise = sif.wfi_req && !m_wfi_r;
        nm = m_mode;
        nt = m_t + 1;
        if (m_mode == M_RUN) begin
            if (rise && !act) begin nm = M_DRAIN; nt = 0; end
        end else if (m_mode == M_DRAIN) begin
            if (act || !sif.wfi_req) nm = M_RUN;
            else if (m_t == DC) begin nm = M_SLEEP; nt = 0; end
            else nt = sif.bus_busy ? 0 : m_t + 1;
        end else if (m_mode == M_SLEEP) begin
            if (m_t >= 2 && (sif.wakeup || m_wseen || !sif.wfi_req)) begin nm = M_WAKE; nt = 0; end
        end else if (m_t == WH - 1) nm = M_RUN;
        m_wseen = (m_mode == M_SLEEP) && (m_wseen || sif.wakeup);
        m_irq   = m_pend & sif.irq_en;
        m_pend  = set | (m_pend & ~sif.irq_clr);
        m_prev  = m_s2;
        m_s2    = m_s1;
        m_s1    = sif.irq_raw;
        m_wfi_r = sif.wfi_req;
        m_idle  = nm == M_SLEEP;
        m_mode  = nm;
        m_t     = nt;
        @(posedge clk_in);
        #1;
        check_outs();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // returns the number of edges until dst_idle rises, or limit+1 if it never does
    task automatic edges_to_idle(input int limit, output int n);
        n = limit + 1;
        for (int k = 1; k <= limit; k++) begin
            step();
            if (sif.dst_idle === 1'b1) begin n = k; break; end
        end
    endtask

    initial begin
        int  n;
        bit  seen;
        sif.wfi_req = 0; sif.bus_busy = 0; sif.wakeup = 0;
        sif.irq_raw = 0; sif.irq_en = 0; sif.irq_clr = 0;
        model_reset();
        #12;
        chk("reset_idle", 32'(sif.dst_idle), 32'd0);
        chk("reset_ack", 32'(sif.sleep_ack), 32'd0);
        chk("reset_irq", 32'({sif.irq3, sif.irq2, sif.irq1}), 32'd0);
        chk("reset_pend", 32'(sif.irq_pending), 32'd0);
        reset_n = 1;
        steps(2);

        // sleep entry latency, then wakeup pulse
        sif.wfi_req = 1;
        edges_to_idle(12, n);
        chk("drain_latency", 32'(n), 32'(DC + 2));
        steps(2);
        sif.wakeup = 1;
        step();
        sif.wakeup = 0;
        chk("wake_fall", 32'(sif.dst_idle), 32'd0);
        steps(WH + 1);
        sif.wfi_req = 0;
        steps(2);

        // bus activity restarts the drain count
        sif.wfi_req = 1;
        steps(3);
        sif.bus_busy = 1;
        steps(2);
        sif.bus_busy = 0;
        edges_to_idle(12, n);
        chk("busy_restart", 32'(n), 32'(DC + 1));
        steps(2);
        sif.wfi_req = 0;
        step();
        chk("wfi_escape", 32'(sif.dst_idle), 32'd0);
        steps(WH + 2);

        // enabled IRQ during DRAIN aborts
        sif.irq_en = 3'b010;
        sif.wfi_req = 1;
        step();
        sif.irq_raw = 3'b010;
        steps(3);
        chk("irq_pend_lat", 32'(sif.irq_pending), 32'b010);
        seen = 0;
        for (int k = 0; k < 8; k++) begin step(); seen |= sif.dst_idle; end
        chk("abort_no_idle", 32'(seen), 32'd0);
        sif.wfi_req = 0; sif.irq_raw = 0;
        steps(3);
        sif.irq_clr = 3'b111;
        step();
        sif.irq_clr = 0;
        chk("pend_cleared", 32'(sif.irq_pending), 32'd0);

        // disabled IRQ does not abort
        sif.irq_en = 3'b000;
        sif.wfi_req = 1;
        step();
        sif.irq_raw = 3'b010;
        edges_to_idle(12, n);
        chk("masked_no_abort", 32'(n <= 12), 32'd1);

        // interrupt while asleep, then clear collides with set
        sif.irq_en = 3'b001;
        sif.irq_raw = 3'b011;
        steps(4);
        chk("irq1_lat", 32'(sif.irq1), 32'd1);
        sif.irq_clr = 3'b001;
        step();
        sif.irq_clr = 0;
        chk("set_wins", 32'(sif.irq_pending[0]), 32'(!EDGE));

        // async reset mid-SLEEP
        chk("still_sleep", 32'(sif.dst_idle), 32'd1);
        reset_n = 0;
        #2;
        chk("areset_idle", 32'(sif.dst_idle), 32'd0);
        chk("areset_ack", 32'(sif.sleep_ack), 32'd0);
        chk("areset_irq", 32'({sif.irq3, sif.irq2, sif.irq1}), 32'd0);
        chk("areset_pend", 32'(sif.irq_pending), 32'd0);
        sif.wfi_req = 0; sif.irq_raw = 0; sif.irq_en = 0;
        model_reset();
        #2;
        reset_n = 1;
        steps(2);

        // level source held high versus clear
        sif.irq_raw = 3'b100;
        steps(4);
        sif.irq_clr = 3'b100;
        step();
        sif.irq_clr = 0;
        chk("held_clr", 32'(sif.irq_pending[2]), 32'(!EDGE));
        step();
        chk("held_clr_next", 32'(sif.irq_pending[2]), 32'(!EDGE));
        sif.irq_raw = 0;
        steps(3);
        sif.irq_clr = 3'b111;
        step();
        sif.irq_clr = 0;

        // randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 15) == 0) sif.wfi_req = ~sif.wfi_req;
            sif.bus_busy = $urandom_range(0, 3) == 0;
            sif.wakeup   = $urandom_range(0, 7) == 0;
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 31) == 0) sif.irq_raw[b] = ~sif.irq_raw[b];
                sif.irq_clr[b] = $urandom_range(0, 7) == 0;
            end
            if ($urandom_range(0, 63) == 0) sif.irq_en = 3'($urandom_range(0, 7));
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
